// File: rtl/present_round_engine_pkg.sv
// present_round_engine_pkg: shared constants for the PRESENT-80 round engine.
//   SBOX/SBOX_INV : forward and inverse 4-bit S-box tables
//   ROUNDS        : number of full rounds of PRESENT-80
//   IDLE/KEYEXP/ROUND/DONE : FSM state encodings
//   p_layer/p_layer_inv    : 64-bit bit permutation and its inverse
package present_round_engine_pkg;

    localparam int ROUNDS = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] KEYEXP = 2'd1;
    localparam logic [1:0] ROUND  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Bit j moves to 16*j mod 63; bit 63 stays in place.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y[63] = x[63];
        for (int j = 0; j < 63; j++) y[(16 * j) % 63] = x[j];
        return y;
    endfunction

    function automatic logic [63:0] p_layer_inv(input logic [63:0] x);
        logic [63:0] y;
        y[63] = x[63];
        for (int j = 0; j < 63; j++) y[j] = x[(16 * j) % 63];
        return y;
    endfunction

endpackage

// File: rtl/present_round_engine_if.sv
// present_round_engine_if: request/result bundle between the bus-register wrapper and the engine.
//   load    : start request, a start is its rising edge
//   control : 0 = encrypt, 1 = decrypt
//   idat    : input block
//   key     : 80-bit cipher key
//   odat    : result block, held until the next completion
//   done    : result valid
interface present_round_engine_if;
    logic        load;
    logic        control;
    logic [63:0] idat;
    logic [79:0] key;
    logic [63:0] odat;
    logic        done;

    modport master (output load, control, idat, key, input odat, done);
    modport slave  (input load, control, idat, key, output odat, done);
endinterface

// File: rtl/present_round_engine_sbox.sv
// present_round_engine_sbox: single 4-bit PRESENT S-box, forward or inverse.
//   inv  : 1 selects the inverse table
//   din  : input nibble
//   dout : substituted nibble
module present_round_engine_sbox
    import present_round_engine_pkg::*;
(
    input  logic       inv,
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = inv ? SBOX_INV[din] : SBOX[din];
endmodule

// File: rtl/present_round_engine.sv
// present_round_engine: iterative PRESENT-80 encrypt/decrypt, one round per clock.
//   clk    : rising-edge clock
//   iReset : asynchronous active-high reset
//   bus    : slave side of present_round_engine_if (load/control/idat/key in, odat/done out)
module present_round_engine #(
    parameter int ROUNDS = 31
) (
    input  logic                        clk,
    input  logic                        iReset,
    present_round_engine_if.slave       bus
);
    import present_round_engine_pkg::*;

    localparam logic [4:0] RC_LAST = 5'(ROUNDS);

    logic [1:0]  state_q, state_d;
    logic        load_q;
    logic        mode_q, mode_d;
    logic [63:0] st_q, st_d;
    logic [79:0] kr_q, kr_d;
    logic [4:0]  rc_q, rc_d;
    logic [63:0] odat_q, odat_d;
    logic        done_q, done_d;

    logic        start;
    logic        key_inv;
    logic [3:0]  key_nib_in, key_nib_out;
    logic [79:0] key_rot, key_fwd, key_xor, key_pre_rot, key_bwd;
    logic [63:0] sb_in, sb_out, enc_next, dec_next;

    // A held load never restarts: only its rising edge in IDLE/DONE counts.
    assign start = bus.load & ~load_q & (state_q == IDLE || state_q == DONE);

    // One shared key S-box: forward for the key schedule, inverse only while decrypt rounds run backwards.
    assign key_inv    = mode_q & (state_q == ROUND);
    assign key_rot    = {kr_q[18:0], kr_q[79:19]};
    assign key_nib_in = key_inv ? kr_q[79:76] : key_rot[79:76];
    assign key_fwd    = {key_nib_out, key_rot[75:20], key_rot[19:15] ^ rc_q, key_rot[14:0]};
    assign key_xor    = {kr_q[79:20], kr_q[19:15] ^ rc_q, kr_q[14:0]};
    assign key_pre_rot = {key_nib_out, key_xor[75:0]};
    assign key_bwd    = {key_pre_rot[60:0], key_pre_rot[79:61]};

    present_round_engine_sbox u_key_sbox (
        .inv  (key_inv),
        .din  (key_nib_in),
        .dout (key_nib_out)
    );

    assign sb_in = mode_q ? p_layer_inv(st_q) : st_q ^ kr_q[79:16];

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        present_round_engine_sbox u_sbox (
            .inv  (mode_q),
            .din  (sb_in[4*n +: 4]),
            .dout (sb_out[4*n +: 4])
        );
    end

    assign enc_next = p_layer(sb_out);
    assign dec_next = sb_out ^ key_bwd[79:16];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        st_d    = st_q;
        kr_d    = kr_q;
        rc_d    = rc_q;
        odat_d  = odat_q;
        done_d  = done_q;
        if (start) begin
            st_d    = bus.idat;
            kr_d    = bus.key;
            mode_d  = bus.control;
            rc_d    = 5'd1;
            done_d  = 1'b0;
            state_d = bus.control ? KEYEXP : ROUND;
        end else begin
            case (state_q)
                KEYEXP: begin
                    kr_d = key_fwd;
                    // Last expansion step: whiten with K32 now and run rounds downwards from the top.
                    if (rc_q == RC_LAST) begin
                        st_d    = st_q ^ key_fwd[79:16];
                        state_d = ROUND;
                    end else begin
                        rc_d = rc_q + 5'd1;
                    end
                end
                ROUND: begin
                    if (mode_q) begin
                        st_d = dec_next;
                        kr_d = key_bwd;
                        if (rc_q == 5'd1) begin
                            odat_d  = dec_next;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            rc_d = rc_q - 5'd1;
                        end
                    end else begin
                        st_d = enc_next;
                        kr_d = key_fwd;
                        // Final round also applies K32, which is the key being produced this cycle.
                        if (rc_q == RC_LAST) begin
                            odat_d  = enc_next ^ key_fwd[79:16];
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            rc_d = rc_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            mode_q  <= 1'b0;
            st_q    <= '0;
            kr_q    <= '0;
            rc_q    <= '0;
            odat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= bus.load;
            mode_q  <= mode_d;
            st_q    <= st_d;
            kr_q    <= kr_d;
            rc_q    <= rc_d;
            odat_q  <= odat_d;
            done_q  <= done_d;
        end
    end

    assign bus.odat = odat_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_present_round_engine.sv
// tb_present_round_engine: scoreboard bench for present_round_engine against a round-key-array reference model.
module tb_present_round_engine;

    logic clk = 1'b0;
    logic iReset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    present_round_engine_if bus();

    present_round_engine #(.ROUNDS(31)) dut (
        .clk    (clk),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] v;
        int          lat;
        int          c0;
    } exp_t;

    exp_t sb_q[$];

    logic [3:0] s_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] si_t [16];

    function automatic logic [63:0] m_sub(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = inv ? si_t[x[4*n +: 4]] : s_t[x[4*n +: 4]];
        return y;
    endfunction

    function automatic logic [63:0] m_perm(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        y = x;
        for (int j = 0; j < 63; j++) begin
            if (inv) y[j] = x[(j * 16) % 63];
            else     y[(j * 16) % 63] = x[j];
        end
        return y;
    endfunction

    function automatic logic [63:0] m_cipher(input bit dec, input logic [63:0] d, input logic [79:0] k);
        logic [63:0] rk [33];
        logic [63:0] s;
        for (int i = 1; i <= 32; i++) begin
            rk[i] = k[79:16];
            k = (k << 61) | (k >> 19);
            k[79:76] = s_t[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(i);
        end
        s = d;
        if (!dec) begin
            for (int i = 1; i <= 31; i++) s = m_perm(m_sub(s ^ rk[i], 1'b0), 1'b0);
            return s ^ rk[32];
        end
        s = s ^ rk[32];
        for (int i = 31; i >= 1; i--) s = m_sub(m_perm(s, 1'b1), 1'b1) ^ rk[i];
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic ctl, input logic [63:0] d, input logic [79:0] k,
                         input logic [63:0] exp_v, input bit hold);
        exp_t e;
        @(negedge clk);
        bus.control = ctl;
        bus.idat    = d;
        bus.key     = k;
        bus.load    = 1'b1;
        e.v   = exp_v;
        e.lat = ctl ? 63 : 32;
        e.c0  = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        if (!hold) bus.load = 1'b0;
        chk("done_drop", 64'(bus.done), 64'd0);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        chk("done_timeout", 64'(bus.done), 64'd1);
    endtask

    // Monitor: each rising done retires one scoreboard entry.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done && !prev) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("odat", bus.odat, e.v);
                    chk("latency", 64'(cyc - e.c0), 64'(e.lat));
                end
            end
            prev = bus.done;
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d, d2;
        logic [79:0] k, k2;
        logic        c;
        int          low_cnt;
        for (int i = 0; i < 16; i++) si_t[s_t[i]] = 4'(i);
        bus.load = 1'b0;
        bus.control = 1'b0;
        bus.idat = '0;
        bus.key = '0;
        repeat (3) @(negedge clk);
        chk("reset_odat", bus.odat, 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        iReset = 1'b0;
        repeat (2) @(negedge clk);

        issue(1'b0, 64'd0, 80'd0, 64'h5579C1387B228445, 1'b0);
        wait_done(80);
        issue(1'b0, 64'd0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0);
        wait_done(80);
        issue(1'b0, {64{1'b1}}, 80'd0, 64'hA112FFC72F68417B, 1'b0);
        wait_done(80);
        issue(1'b1, 64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}}, 1'b0);
        wait_done(80);

        for (int t = 0; t < 8; t++) begin
            d = {$urandom, $urandom};
            k = {16'($urandom), $urandom, $urandom};
            c = 1'($urandom_range(0, 1));
            issue(c, d, k, m_cipher(c, d, k), 1'b0);
            wait_done(80);
        end

        // Held load: exactly one operation, result stays put.
        d = {$urandom, $urandom};
        k = {16'($urandom), $urandom, $urandom};
        issue(1'b1, d, k, m_cipher(1'b1, d, k), 1'b1);
        wait_done(80);
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.done) low_cnt++;
        end
        chk("hold_done_low_cycles", 64'(low_cnt), 64'd0);
        chk("hold_odat_stable", bus.odat, m_cipher(1'b1, d, k));
        bus.load = 1'b0;
        @(negedge clk);
        issue(1'b0, d, k, m_cipher(1'b0, d, k), 1'b0);
        wait_done(80);

        // Mid-run start and input changes are ignored.
        d = {$urandom, $urandom};
        k = {16'($urandom), $urandom, $urandom};
        issue(1'b0, d, k, m_cipher(1'b0, d, k), 1'b0);
        repeat (8) @(negedge clk);
        d2 = {$urandom, $urandom};
        k2 = {16'($urandom), $urandom, $urandom};
        bus.load = 1'b1;
        bus.control = 1'b1;
        bus.idat = d2;
        bus.key = k2;
        @(negedge clk);
        bus.load = 1'b0;
        wait_done(80);

        // Reset in the middle of encryption rounds.
        issue(1'b0, 64'd0, 80'd0, 64'h5579C1387B228445, 1'b0);
        repeat (14) @(negedge clk);
        iReset = 1'b1;
        #1;
        chk("abort_odat", bus.odat, 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        sb_q.delete();
        @(negedge clk);
        iReset = 1'b0;
        repeat (40) @(negedge clk);
        chk("idle_odat", bus.odat, 64'd0);
        chk("idle_done", 64'(bus.done), 64'd0);
        issue(1'b1, 64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}}, 1'b0);
        wait_done(80);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
